// File: rtl/alu_op_sequencer.sv
// Issues one operation per command handshake to the selected ALU unit and returns its result.
// Latency: result 2 cycles after acceptance (timeout: TIMEOUT_CYC+1); result held, commands blocked until Res_Ready.
module alu_op_sequencer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 17,
  parameter int TIMEOUT_CYC    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Cmd_Valid,
  output logic                      Cmd_Ready,
  input  logic [IN_DATA_WIDTH-1:0]  Cmd_A,
  input  logic [IN_DATA_WIDTH-1:0]  Cmd_B,
  input  logic [3:0]                Cmd_FUNC,
  output logic [IN_DATA_WIDTH-1:0]  A,
  output logic [IN_DATA_WIDTH-1:0]  B,
  output logic [1:0]                ALU_FUNC,
  output logic                      Arith_Enable,
  output logic                      Logic_Enable,
  output logic                      CMP_Enable,
  output logic                      Shift_Enable,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Shift_OUT,
  input  logic                      Arith_Flag,
  input  logic                      Logic_Flag,
  input  logic                      CMP_Flag,
  input  logic                      Shift_Flag,
  output logic                      Res_Valid,
  input  logic                      Res_Ready,
  output logic [OUT_DATA_WIDTH-1:0] Res_Data,
  output logic                      Res_Err
);

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [1:0]                unit_sel;
  logic [1:0]                unit_sel_nxt;
  logic [CNT_W-1:0]          to_cnt;
  logic [CNT_W-1:0]          to_cnt_nxt;
  logic [3:0]                en;
  logic [3:0]                en_nxt;
  logic [IN_DATA_WIDTH-1:0]  a_nxt;
  logic [IN_DATA_WIDTH-1:0]  b_nxt;
  logic [1:0]                func_nxt;
  logic                      res_vld_nxt;
  logic                      res_err_nxt;
  logic [OUT_DATA_WIDTH-1:0] res_dat_nxt;
  logic                      sel_flag;
  logic [OUT_DATA_WIDTH-1:0] sel_out;
  logic                      cmd_acc;
  logic                      to_hit;

  assign Cmd_Ready = (state == S_IDLE);
  assign cmd_acc   = Cmd_Valid && Cmd_Ready;
  assign to_hit    = (to_cnt == TO_LAST);

  // en bit order follows the unit select encoding: arith, logic, cmp, shift
  assign Arith_Enable = en[0];
  assign Logic_Enable = en[1];
  assign CMP_Enable   = en[2];
  assign Shift_Enable = en[3];

  // Only the latched unit's flag and result are visible to the FSM
  always_comb begin
    sel_flag = Arith_Flag;
    sel_out  = Arith_OUT;
    case (unit_sel)
      2'b01: begin
        sel_flag = Logic_Flag;
        sel_out  = Logic_OUT;
      end
      2'b10: begin
        sel_flag = CMP_Flag;
        sel_out  = CMP_OUT;
      end
      2'b11: begin
        sel_flag = Shift_Flag;
        sel_out  = Shift_OUT;
      end
      default: begin
        sel_flag = Arith_Flag;
        sel_out  = Arith_OUT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_acc) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sel_flag || to_hit) state_nxt = S_HOLD;
      S_HOLD:  if (Res_Ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    unit_sel_nxt = unit_sel;
    to_cnt_nxt   = to_cnt;
    en_nxt       = '0;
    a_nxt        = A;
    b_nxt        = B;
    func_nxt     = ALU_FUNC;
    res_vld_nxt  = Res_Valid;
    res_err_nxt  = Res_Err;
    res_dat_nxt  = Res_Data;
    case (state)
      S_IDLE: begin
        if (cmd_acc) begin
          a_nxt        = Cmd_A;
          b_nxt        = Cmd_B;
          func_nxt     = Cmd_FUNC[1:0];
          unit_sel_nxt = Cmd_FUNC[3:2];
          en_nxt       = 4'b0001 << Cmd_FUNC[3:2];
        end
      end
      S_ISSUE: begin
        to_cnt_nxt = '0;
      end
      S_WAIT: begin
        if (sel_flag) begin
          res_dat_nxt = sel_out;
          res_err_nxt = 1'b0;
          res_vld_nxt = 1'b1;
        end else if (to_hit) begin
          res_dat_nxt = '0;
          res_err_nxt = 1'b1;
          res_vld_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // Res_Data deliberately survives the handshake; only valid/err drop
        if (Res_Ready) begin
          res_vld_nxt = 1'b0;
          res_err_nxt = 1'b0;
        end
      end
      default: begin
        en_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      unit_sel  <= '0;
      to_cnt    <= '0;
      en        <= '0;
      A         <= '0;
      B         <= '0;
      ALU_FUNC  <= '0;
      Res_Valid <= 1'b0;
      Res_Err   <= 1'b0;
      Res_Data  <= '0;
    end else begin
      unit_sel  <= unit_sel_nxt;
      to_cnt    <= to_cnt_nxt;
      en        <= en_nxt;
      A         <= a_nxt;
      B         <= b_nxt;
      ALU_FUNC  <= func_nxt;
      Res_Valid <= res_vld_nxt;
      Res_Err   <= res_err_nxt;
      Res_Data  <= res_dat_nxt;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side initiator for the 16-bit ALU execution units: arithmetic, logic, compare and shift.
- Accepts one operation per valid/ready handshake and drives registered operands, ALU_FUNC and a one-cycle enable to the selected unit.
- Waits for that unit's registered result flag, captures the result and presents it downstream on a valid/ready result port.
- Sits between the instruction/register-file front end and the four units. It is the driver side of the unit interface (Enable/FUNC in, OUT/Flag back).

Parameters:
IN_DATA_WIDTH, 16, operand width (A, B)
OUT_DATA_WIDTH, 17, unit result width (matches unit OUT buses)
TIMEOUT_CYC, 4, max cycles in WAIT for the selected flag before error completion (legal range 2..15)

Ports:
CLK  input  1  clock, all flops rising edge
RST  input  1  reset, asynchronous, active-low
Cmd_Valid  input  1  command present
Cmd_Ready  output  1  sequencer can accept a command
Cmd_A  input  IN_DATA_WIDTH  operand A
Cmd_B  input  IN_DATA_WIDTH  operand B
Cmd_FUNC  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit ALU_FUNC
A  output  IN_DATA_WIDTH  registered operand A to units
B  output  IN_DATA_WIDTH  registered operand B to units
ALU_FUNC  output  2  registered unit function
Arith_Enable / Logic_Enable / CMP_Enable / Shift_Enable  output  1 each  unit enables, one-hot, one-cycle pulse
Arith_OUT / Logic_OUT / CMP_OUT / Shift_OUT  input  OUT_DATA_WIDTH each  registered unit results
Arith_Flag / Logic_Flag / CMP_Flag / Shift_Flag  input  1 each  unit result-valid flags
Res_Valid  output  1  result available
Res_Ready  input  1  downstream accepts result
Res_Data  output  OUT_DATA_WIDTH  captured result
Res_Err  output  1  result is a timeout completion

Behaviour:
- Reset (RST low, any time, including mid-operation):
  - State goes to IDLE and all outputs go to 0.
  - Exception: Cmd_Ready is 1 while reset is asserted.
  - The timeout counter and the latched unit select clear.
  - Any in-flight operation is abandoned; no result is produced for it.
- FSM states: IDLE, ISSUE, WAIT, HOLD. All outputs are registered, except Cmd_Ready, which is decoded as (state == IDLE).
- IDLE:
  - On Cmd_Valid && Cmd_Ready at an edge: latch Cmd_A→A, Cmd_B→B, Cmd_FUNC[1:0]→ALU_FUNC and the unit select.
  - Assert exactly one enable per Cmd_FUNC[3:2], then go to ISSUE.
  - Cmd_Valid low: stay in IDLE, enables 0.
- ISSUE (exactly 1 cycle):
  - The selected enable is high for this cycle only.
  - Next edge: clear all enables, clear the timeout counter, go to WAIT.
- WAIT:
  - Only the selected unit's flag is examined; flags from other units are ignored.
  - If the selected flag is 1 at an edge: Res_Data ← selected unit OUT, Res_Err ← 0, Res_Valid ← 1, go to HOLD.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 with no flag: Res_Data ← 0, Res_Err ← 1, Res_Valid ← 1, go to HOLD.
- HOLD:
  - Res_Valid, Res_Data and Res_Err stay stable until Res_Ready is 1 at an edge.
  - On that edge: Res_Valid ← 0, Res_Err ← 0, go to IDLE. Res_Data keeps its value.
  - Cmd_Ready stays 0 throughout HOLD, so no command overlaps a pending result.
- A, B and ALU_FUNC hold their values from ISSUE until the next accepted command; the units always see stable operands.
- Nominal latency (acceptance edge = E0):
  - Enable high in E0..E1.
  - The unit registers its result at E1; its flag is high in E1..E2.
  - The sequencer captures at E2; Res_Valid is high from E2.
  - Minimum issue interval: 4 cycles, with Res_Ready held high.
- Res_Ready asserted while Res_Valid is 0: ignored.
- Cmd_Valid may drop without acceptance; no state change results.

Test Plan:
- Shift right: reset, then Cmd_A=16'h8001, Cmd_FUNC=4'b1100 with a shift-unit model → Shift_Enable is a single 1-cycle pulse; Res_Valid rises 2 cycles after acceptance; Res_Data=17'h04000; Res_Err=0.
- Shift left of B: Cmd_B=16'h8001, Cmd_FUNC=4'b1111 → ALU_FUNC=2'b11; Res_Data=17'h10002; the other three enables stay 0 throughout.
- Backpressure: Res_Ready low for 5 cycles after Res_Valid → Res_Data/Res_Err/Res_Valid stable, Cmd_Ready=0 despite Cmd_Valid=1. Raising Res_Ready → IDLE next cycle, then the next command is accepted.
- Timeout and wrong-unit flag: Cmd_FUNC=4'b0100 (logic); the model pulses only Arith_Flag and never Logic_Flag → after TIMEOUT_CYC=4 cycles in WAIT, Res_Valid=1, Res_Err=1, Res_Data=0.
- Reset mid-operation: assert RST low during WAIT → all outputs 0 immediately. Release → Cmd_Ready=1, no Res_Valid for the aborted command, and a following command (arith, FUNC=4'b0000) completes normally.
- Back-to-back: four commands, one per unit, with Res_Ready tied high → each completes in 4 cycles, results in order, exactly one enable pulse per command.
